bayer_timing_ctrl: RTL



---
 rtl/bayer_pkg.sv | 26 ++
 rtl/bayer_sync_delay.sv | 30 +++
 rtl/bayer_timing_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bayer_pkg.sv
// Shared types and defaults for the Bayer-to-RGB pipeline.
// Imported by the timing controller and the interpolation datapath.
package bayer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_FILL = 2'd1;
    localparam state_t ST_RUN  = 2'd2;

    localparam logic [1:0] BAYER_RGGB = 2'b00;
    localparam logic [1:0] BAYER_GRBG = 2'b01;
    localparam logic [1:0] BAYER_GBRG = 2'b10;
    localparam logic [1:0] BAYER_BGGR = 2'b11;

    localparam int unsigned DEF_IMG_W   = 640;
    localparam int unsigned DEF_IMG_H   = 480;
    localparam int unsigned DEF_LATENCY = 11;
    localparam int unsigned DEF_CNT_W   = 12;

    function automatic logic [1:0] bayer_phase_of(input logic row_lsb, input logic col_lsb,
                                                  input logic [1:0] pat);
        return {row_lsb ^ pat[1], col_lsb ^ pat[0]};
    endfunction

endpackage

// File: rtl/bayer_sync_delay.sv
// Fixed-depth shift register that re-times the raw sync bundle to the
// interpolated pixel stream.
module bayer_sync_delay
    import bayer_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = DEF_LATENCY + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: every stage is reset, not just the output, so no stale sync pulse
    // can emerge from the line after a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/bayer_timing_ctrl.sv
// Pixel/line tracking, line-buffer enables, Bayer phase, border flags and
// sync re-timing. Optional sticky geometry check: BAYER_GEOM_CHECK_EN.
module bayer_timing_ctrl
    import bayer_pkg::*;
#(
    parameter int unsigned IMG_W     = DEF_IMG_W,
    parameter int unsigned IMG_H     = DEF_IMG_H,
    parameter int unsigned LATENCY   = DEF_LATENCY,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter logic [1:0]  BAYER_PAT = BAYER_RGGB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vs_in,
    input  logic             hs_in,
    input  logic             de_in,
    output logic             line_wr_en,
    output logic             line_rd_en,
    output logic             win_valid,
    output logic [CNT_W-1:0] x_cnt,
    output logic [CNT_W-1:0] y_cnt,
    output logic [1:0]       bayer_phase,
    output logic             edge_l,
    output logic             edge_r,
    output logic             edge_t,
    output logic             edge_b,
    output logic             frame_start,
    output logic             vs_out,
    output logic             hs_out,
    output logic             de_out,
    output logic             err_geom
);

    localparam logic [CNT_W-1:0] X_MAX   = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] Y_MAX   = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   PIX_ONE = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   PIX_SAT = (CNT_W+1)'(IMG_W + 1);

    state_t           state, state_nxt;
    logic             vs_q, de_q;
    logic             vs_rise, de_fall;
    // Pixels seen on the current line; runs one past IMG_W so long lines are visible.
    logic [CNT_W:0]   pix_cnt, pix_nxt;
    logic [CNT_W-1:0] x_nxt, y_nxt;
    logic             wr_nxt, rd_nxt, de_acc;
    logic [2:0]       sync_dly;

    assign vs_rise = vs_in & ~vs_q;
    assign de_fall = ~de_in & de_q;

    // NOTE: every signal gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        x_nxt     = x_cnt;
        y_nxt     = y_cnt;
        pix_nxt   = pix_cnt;
        wr_nxt    = 1'b0;
        rd_nxt    = 1'b0;
        de_acc    = 1'b0;
        if (vs_rise) begin
            // Frame start aborts whatever is in flight, even mid-line.
            state_nxt = ST_FILL;
            x_nxt     = '0;
            y_nxt     = '0;
            pix_nxt   = de_in ? PIX_ONE : '0;
            wr_nxt    = de_in;
            de_acc    = de_in;
        end else if (state != ST_IDLE) begin
            de_acc = de_in;
            wr_nxt = de_in;
            rd_nxt = de_in & (state == ST_RUN);
            if (de_in) begin
                x_nxt = (pix_cnt < {1'b0, X_MAX}) ? pix_cnt[CNT_W-1:0] : X_MAX;
                if (pix_cnt != PIX_SAT) pix_nxt = pix_cnt + PIX_ONE;
            end else if (de_q) begin
                x_nxt   = '0;
                pix_nxt = '0;
                if (y_cnt != Y_MAX) y_nxt = y_cnt + CNT_ONE;
                if (state == ST_FILL)    state_nxt = ST_RUN;
                else if (y_cnt == Y_MAX) state_nxt = ST_IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            pix_cnt     <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            line_wr_en  <= 1'b0;
            line_rd_en  <= 1'b0;
            win_valid   <= 1'b0;
            frame_start <= 1'b0;
            bayer_phase <= 2'b00;
            edge_l      <= 1'b0;
            edge_r      <= 1'b0;
            edge_t      <= 1'b0;
            edge_b      <= 1'b0;
        end else begin
            state       <= state_nxt;
            vs_q        <= vs_in;
            de_q        <= de_in;
            pix_cnt     <= pix_nxt;
            x_cnt       <= x_nxt;
            y_cnt       <= y_nxt;
            line_wr_en  <= wr_nxt;
            line_rd_en  <= rd_nxt;
            win_valid   <= rd_nxt;
            frame_start <= vs_rise;
            bayer_phase <= bayer_phase_of(y_nxt[0], x_nxt[0], BAYER_PAT);
            edge_l      <= de_acc & (x_nxt == '0);
            edge_r      <= de_acc & (x_nxt == X_MAX);
            edge_t      <= de_acc & (y_nxt == '0);
            edge_b      <= de_acc & (y_nxt == Y_MAX);
        end
    end

    bayer_sync_delay #(
        .WIDTH(3),
        .DEPTH(LATENCY + 1)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .din ({vs_in, hs_in, de_in}),
        .dout(sync_dly)
    );

    assign vs_out = sync_dly[2];
    assign hs_out = sync_dly[1];
    assign de_out = sync_dly[0];

`ifdef BAYER_GEOM_CHECK_EN
    localparam logic [CNT_W:0] PIX_LINE = (CNT_W+1)'(IMG_W);

    logic geom_bad;

    // A frame start outside IDLE means the previous frame came up short.
    assign geom_bad = vs_rise ? (state != ST_IDLE)
                              : ((state != ST_IDLE) && de_fall && (pix_cnt != PIX_LINE));

    always_ff @(posedge clk) begin
        if (rst)           err_geom <= 1'b0;
        else if (geom_bad) err_geom <= 1'b1;
    end
`else
    assign err_geom = 1'b0;
`endif

endmodule
